// File: rtl/video_tap_pkg.sv
// Shared definitions for the video line tap controller: FSM state encoding
// and default pixel/address widths.
package video_tap_pkg;

    localparam int DSIZE_DEF = 24;
    localparam int ASIZE_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } tap_state_e;

endpackage

// File: rtl/video_sync_edge.sv
// Registered edge detector. The edge output is combinational from the live input
// and its registered copy, so an edge acts in the cycle it arrives.
module video_sync_edge #(
    parameter bit DETECT_FALL = 1'b0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sig_d;

    // previous-cycle copy of the input
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    always_comb begin
        if (DETECT_FALL) begin
            o_edge = ~i_sig & r_sig_d;
        end else begin
            o_edge = i_sig & ~r_sig_d;
        end
    end

endmodule

// File: rtl/video_line_tap_ctrl.sv
// Line-delay controller: drives a dual-port line RAM as one circular line buffer and
// emits each pixel with its previous-line tap. Macro VIDEO_TAP_ZERO_FILL_EN: invalid taps read 0.
module video_line_tap_ctrl
    import video_tap_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic [DSIZE-1:0] in_data,
    output logic             ram_wr_en,
    output logic [ASIZE-1:0] ram_wr_addr,
    output logic [DSIZE-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output logic [ASIZE-1:0] ram_rd_addr,
    input  logic [DSIZE-1:0] ram_rd_data,
    output logic             out_vs,
    output logic             out_de,
    output logic [DSIZE-1:0] out_data,
    output logic [DSIZE-1:0] out_tap,
    output logic             out_tap_vld,
    output logic             line_ovf
);

    localparam logic [ASIZE-1:0] COL_ZERO = {ASIZE{1'b0}};
    localparam logic [ASIZE-1:0] COL_ONE  = {{(ASIZE-1){1'b0}}, 1'b1};
    localparam logic [ASIZE-1:0] COL_MAX  = {ASIZE{1'b1}};
    localparam logic [ASIZE:0]   LEN_ZERO = {(ASIZE+1){1'b0}};
    localparam logic [ASIZE:0]   LEN_FULL = {1'b1, {ASIZE{1'b0}}};

    tap_state_e       r_state, w_state_nxt, w_state_eff;
    logic             w_vs_rise, w_de_fall, w_active, w_run;
    logic [ASIZE-1:0] r_col, w_col, w_col_nxt;
    logic             r_full, w_full, w_full_nxt;
    logic             w_pix, w_acc, w_tap_vld;
    logic [ASIZE:0]   r_prev_len, w_len;
    logic             r_ovf, r_wr_en;
    logic [ASIZE-1:0] r_wr_addr;
    logic [DSIZE-1:0] r_wr_data;
    logic             r_s1_vs, r_s1_de, r_s1_vld;
    logic [DSIZE-1:0] r_s1_data, w_tap_fill, w_tap_sel;
    logic             r_out_vs, r_out_de, r_out_vld;
    logic [DSIZE-1:0] r_out_data, r_out_tap;

    video_sync_edge #(.DETECT_FALL(1'b0)) u_vs_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .i_sig  (in_vs),
        .o_edge (w_vs_rise)
    );

    video_sync_edge #(.DETECT_FALL(1'b1)) u_de_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .i_sig  (in_de),
        .o_edge (w_de_fall)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_rise) begin
            w_state_nxt = ST_FIRST;
        end else if ((r_state == ST_FIRST) && w_de_fall) begin
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // a vs rise applies to the pixel arriving with it
    always_comb begin
        w_active = 1'b0;
        w_run    = 1'b0;
        if (w_vs_rise) begin
            w_state_eff = ST_FIRST;
        end else begin
            w_state_eff = r_state;
        end
        case (w_state_eff)
            ST_IDLE:  begin w_active = 1'b0; w_run = 1'b0; end
            ST_FIRST: begin w_active = 1'b1; w_run = 1'b0; end
            ST_RUN:   begin w_active = 1'b1; w_run = 1'b1; end
            default:  begin w_active = 1'b0; w_run = 1'b0; end
        endcase
    end

    // r_full marks that column COL_MAX is used; later pixels of the line are dropped
    always_comb begin
        w_col      = w_vs_rise ? COL_ZERO : r_col;
        w_full     = w_vs_rise ? 1'b0 : r_full;
        w_pix      = in_de & w_active;
        w_acc      = w_pix & ~w_full;
        w_col_nxt  = w_col;
        w_full_nxt = w_full;
        if (w_de_fall) begin
            w_col_nxt  = COL_ZERO;
            w_full_nxt = 1'b0;
        end else if (w_acc) begin
            if (w_col == COL_MAX) begin
                w_full_nxt = 1'b1;
            end else begin
                w_col_nxt = w_col + COL_ONE;
            end
        end else begin
            w_col_nxt  = w_col;
            w_full_nxt = w_full;
        end
        w_len     = r_full ? LEN_FULL : {1'b0, r_col};
        w_tap_vld = w_run & w_acc & ({1'b0, w_col} < r_prev_len);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= COL_ZERO;
            r_full     <= 1'b0;
            r_prev_len <= LEN_ZERO;
            r_ovf      <= 1'b0;
        end else begin
            r_col  <= w_col_nxt;
            r_full <= w_full_nxt;
            if (w_vs_rise) begin
                r_prev_len <= LEN_ZERO;
                r_ovf      <= 1'b0;
            end else begin
                r_prev_len <= w_de_fall ? w_len : r_prev_len;
                r_ovf      <= r_ovf | (w_pix & w_full);
            end
        end
    end

    // write back one cycle after the read, so read and write never collide
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= COL_ZERO;
            r_wr_data <= {DSIZE{1'b0}};
        end else begin
            r_wr_en   <= w_acc;
            r_wr_addr <= w_col;
            r_wr_data <= in_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vs   <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_data <= {DSIZE{1'b0}};
        end else begin
            r_s1_vs   <= in_vs;
            r_s1_de   <= in_de;
            r_s1_vld  <= w_tap_vld;
            r_s1_data <= in_data;
        end
    end

    always_comb begin
`ifdef VIDEO_TAP_ZERO_FILL_EN
        w_tap_fill = {DSIZE{1'b0}};
`else
        w_tap_fill = r_s1_data;
`endif
        w_tap_sel = r_s1_vld ? ram_rd_data : w_tap_fill;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vs   <= 1'b0;
            r_out_de   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= {DSIZE{1'b0}};
            r_out_tap  <= {DSIZE{1'b0}};
        end else begin
            r_out_vs   <= r_s1_vs;
            r_out_de   <= r_s1_de;
            r_out_vld  <= r_s1_vld;
            r_out_data <= r_s1_data;
            r_out_tap  <= w_tap_sel;
        end
    end

    assign ram_rd_en   = w_acc;
    assign ram_rd_addr = w_col;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;
    assign out_vs      = r_out_vs;
    assign out_de      = r_out_de;
    assign out_data    = r_out_data;
    assign out_tap     = r_out_tap;
    assign out_tap_vld = r_out_vld;
    assign line_ovf    = r_ovf;

endmodule

// File: tb/tb_video_line_tap_ctrl.sv
// Bench for video_line_tap_ctrl: two instances (ASIZE=10 and ASIZE=3) with RAM models,
// checked against a line-queue reference model.
module tb_video_line_tap_ctrl;

    localparam int DW = 24;
    localparam int A0 = 10;
    localparam int A1 = 3;

    typedef struct packed {
        logic          vs;
        logic          de;
        logic          vld;
        logic [DW-1:0] data;
        logic [DW-1:0] tap;
    } pix_t;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          in_vs, in_de;
    logic [DW-1:0] in_data;

    logic          d0_wr_en, d0_rd_en, d0_ovs, d0_ode, d0_vld, d0_ovf;
    logic [A0-1:0] d0_wr_addr, d0_rd_addr;
    logic [DW-1:0] d0_wr_data, d0_rd_data, d0_odata, d0_otap;
    logic          d1_wr_en, d1_rd_en, d1_ovs, d1_ode, d1_vld, d1_ovf;
    logic [A1-1:0] d1_wr_addr, d1_rd_addr;
    logic [DW-1:0] d1_wr_data, d1_rd_data, d1_odata, d1_otap;

    logic [DW-1:0] mem0 [0:(1<<A0)-1];
    logic [DW-1:0] mem1 [0:(1<<A1)-1];

    pix_t          s1 [2];
    pix_t          s2 [2];
    logic          ovf_m [2];
    logic          framed [2];
    logic          ran [2];
    logic          pvs [2];
    logic          pde [2];
    int            cur_n [2];
    int            prev_n [2];
    logic [DW-1:0] curbuf [2][0:1023];
    logic [DW-1:0] prevbuf [2][0:1023];
    logic          exp_rd [2];
    logic          exp_wr [2];
    int            exp_rd_addr [2];
    int            exp_wr_addr [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    video_line_tap_ctrl #(.DSIZE(DW), .ASIZE(A0)) dut0 (
        .clock(clock), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .ram_wr_en(d0_wr_en), .ram_wr_addr(d0_wr_addr), .ram_wr_data(d0_wr_data),
        .ram_rd_en(d0_rd_en), .ram_rd_addr(d0_rd_addr), .ram_rd_data(d0_rd_data),
        .out_vs(d0_ovs), .out_de(d0_ode), .out_data(d0_odata), .out_tap(d0_otap),
        .out_tap_vld(d0_vld), .line_ovf(d0_ovf)
    );

    video_line_tap_ctrl #(.DSIZE(DW), .ASIZE(A1)) dut1 (
        .clock(clock), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .ram_wr_en(d1_wr_en), .ram_wr_addr(d1_wr_addr), .ram_wr_data(d1_wr_data),
        .ram_rd_en(d1_rd_en), .ram_rd_addr(d1_rd_addr), .ram_rd_data(d1_rd_data),
        .out_vs(d1_ovs), .out_de(d1_ode), .out_data(d1_odata), .out_tap(d1_otap),
        .out_tap_vld(d1_vld), .line_ovf(d1_ovf)
    );

    always @(posedge clock) begin
        if (d0_wr_en) mem0[d0_wr_addr] <= d0_wr_data;
        if (d0_rd_en) d0_rd_data <= mem0[d0_rd_addr];
        if (d1_wr_en) mem1[d1_wr_addr] <= d1_wr_data;
        if (d1_rd_en) d1_rd_data <= mem1[d1_rd_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] fill_of(input logic [DW-1:0] d);
`ifdef VIDEO_TAP_ZERO_FILL_EN
        return {DW{1'b0}};
`else
        return d;
`endif
    endfunction

    // Reference: a completed line becomes the tap source for the next one
    task automatic model_step(input int k, input logic vs, input logic de,
                              input logic [DW-1:0] d, input logic rstn);
        int   cap;
        pix_t p;
        cap = (k == 0) ? (1 << A0) : (1 << A1);
        exp_wr[k]      = exp_rd[k];
        exp_wr_addr[k] = exp_rd_addr[k];
        exp_rd[k]      = 1'b0;
        if (!rstn) begin
            framed[k] = 1'b0; ran[k] = 1'b0; pvs[k] = 1'b0; pde[k] = 1'b0;
            cur_n[k] = 0; prev_n[k] = 0; ovf_m[k] = 1'b0;
            s1[k] = '0; s2[k] = '0; exp_wr[k] = 1'b0;
            return;
        end
        if (vs && !pvs[k]) begin
            framed[k] = 1'b1; ran[k] = 1'b0; prev_n[k] = 0; cur_n[k] = 0; ovf_m[k] = 1'b0;
        end else if (!de && pde[k]) begin
            if (framed[k]) begin
                for (int i = 0; i < cur_n[k]; i++) prevbuf[k][i] = curbuf[k][i];
                prev_n[k] = cur_n[k];
                ran[k]    = 1'b1;
            end
            cur_n[k] = 0;
        end
        pvs[k] = vs;
        pde[k] = de;
        p.vs = vs; p.de = de; p.data = d; p.vld = 1'b0; p.tap = fill_of(d);
        if (de && framed[k]) begin
            if (cur_n[k] < cap) begin
                exp_rd[k]      = 1'b1;
                exp_rd_addr[k] = cur_n[k];
                if (ran[k] && (cur_n[k] < prev_n[k])) begin
                    p.vld = 1'b1;
                    p.tap = prevbuf[k][cur_n[k]];
                end
                curbuf[k][cur_n[k]] = d;
                cur_n[k]++;
            end else begin
                ovf_m[k] = 1'b1;
            end
        end
        s2[k] = s1[k];
        s1[k] = p;
    endtask

    task automatic check_ram(input int k, input logic rd, input logic [15:0] ra,
                             input logic wr, input logic [15:0] wa);
        check_val($sformatf("d%0d rd_en", k), 64'(rd), 64'(exp_rd[k]));
        if (exp_rd[k]) check_val($sformatf("d%0d rd_addr", k), 64'(ra), 64'(exp_rd_addr[k]));
        check_val($sformatf("d%0d wr_en", k), 64'(wr), 64'(exp_wr[k]));
        if (exp_wr[k]) check_val($sformatf("d%0d wr_addr", k), 64'(wa), 64'(exp_wr_addr[k]));
        check_val($sformatf("d%0d rw_same_addr", k), 64'(rd && wr && (ra == wa)), 64'(0));
    endtask

    task automatic check_out(input int k, input logic vs, input logic de, input logic [DW-1:0] data,
                             input logic [DW-1:0] tap, input logic vld, input logic ovf);
        check_val($sformatf("d%0d out_vs", k), 64'(vs), 64'(s2[k].vs));
        check_val($sformatf("d%0d out_de", k), 64'(de), 64'(s2[k].de));
        check_val($sformatf("d%0d out_data", k), 64'(data), 64'(s2[k].data));
        check_val($sformatf("d%0d out_tap", k), 64'(tap), 64'(s2[k].tap));
        check_val($sformatf("d%0d out_tap_vld", k), 64'(vld), 64'(s2[k].vld));
        check_val($sformatf("d%0d line_ovf", k), 64'(ovf), 64'(ovf_m[k]));
    endtask

    // one clock: drive at negedge, check RAM ports mid-cycle, outputs at next negedge
    task automatic step(input logic vs, input logic de, input logic [DW-1:0] d, input logic rstn);
        in_vs = vs; in_de = de; in_data = d; rst_n = rstn;
        model_step(0, vs, de, d, rstn);
        model_step(1, vs, de, d, rstn);
        #1;
        check_ram(0, d0_rd_en, 16'(d0_rd_addr), d0_wr_en, 16'(d0_wr_addr));
        check_ram(1, d1_rd_en, 16'(d1_rd_addr), d1_wr_en, 16'(d1_wr_addr));
        @(posedge clock);
        @(negedge clock);
        check_out(0, d0_ovs, d0_ode, d0_odata, d0_otap, d0_vld, d0_ovf);
        check_out(1, d1_ovs, d1_ode, d1_odata, d1_otap, d1_vld, d1_ovf);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, DW'($urandom), 1'b1);
    endtask

    task automatic vsync(input int n);
        repeat (n) step(1'b1, 1'b0, DW'($urandom), 1'b1);
    endtask

    task automatic line(input int n, input int blank, input int ln);
        for (int c = 0; c < n; c++) step(1'b0, 1'b1, DW'(ln * 16 + c), 1'b1);
        idle(blank);
    endtask

    task automatic line_rand(input int n, input int blank);
        for (int c = 0; c < n; c++) step(1'b0, 1'b1, DW'($urandom), 1'b1);
        idle(blank);
    endtask

    initial begin
        rst_n = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = '0;
        @(negedge clock);
        repeat (3) step(1'b0, 1'b0, DW'(0), 1'b0);
        idle(2);
        // basic 3-line frame of 8 pixels
        vsync(2); idle(2);
        for (int l = 0; l < 3; l++) line(8, 3, l);
        // line-length changes: 8, 8, 10, 6
        vsync(1); idle(1);
        line(8, 2, 0); line(8, 2, 1); line(10, 2, 2); line(6, 2, 3);
        // overflow on the narrow instance, cleared by the next vs
        vsync(1); idle(1);
        line(10, 2, 0); line(10, 2, 1);
        vsync(1); idle(2);
        line(4, 2, 0);
        // vs rising together with the first pixel of a line
        line(5, 1, 1);
        step(1'b1, 1'b1, DW'(256), 1'b1);
        for (int c = 1; c < 6; c++) step(1'b0, 1'b1, DW'(256 + c), 1'b1);
        idle(2);
        line(7, 2, 2);
        // reset pulse mid-line, DE ignored until the next vs
        vsync(1); idle(1);
        line(8, 2, 0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, DW'(16 + c), 1'b1);
        step(1'b0, 1'b1, DW'(20), 1'b0);
        for (int c = 5; c < 8; c++) step(1'b0, 1'b1, DW'(16 + c), 1'b1);
        idle(2);
        line(8, 2, 2);
        vsync(1); idle(1);
        line(8, 2, 0); line(8, 1, 1); line(8, 1, 2);
        // random frames with 1-cycle blanking/gaps and varied lengths
        repeat (6) begin
            vsync(1 + $urandom_range(0, 1));
            idle($urandom_range(0, 2));
            repeat (8) line_rand(1 + $urandom_range(0, 11), 1 + $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
